// File: rtl/gba_cheat_pkg.sv
// Shared types and code-word layout for the GBA cheat engine.
// Build option: GBA_CHEAT_COMPARE_EN adds per-entry compare storage.
package gba_cheat_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } cheat_size_e;

    localparam int CODE_STROBE_BIT = 128;
    localparam int CODE_FLAGS_LSB  = 96;
    localparam int CODE_ADDR_LSB   = 64;
    localparam int CODE_CMP_LSB    = 32;
    localparam int CODE_REPL_LSB   = 0;

    typedef struct packed {
        logic        valid;
        logic [25:0] addr;
        cheat_size_e size;
`ifdef GBA_CHEAT_COMPARE_EN
        logic        cmp_en;
        logic [31:0] compare;
`endif
        logic [31:0] replace;
    } cheat_entry_t;

    function automatic cheat_entry_t code_to_entry(input logic [128:0] code_w);
        cheat_entry_t e;
        e         = '0;
        e.valid   = 1'b1;
        e.addr    = code_w[CODE_ADDR_LSB +: 26];
        e.size    = cheat_size_e'(code_w[CODE_FLAGS_LSB +: 2]);
`ifdef GBA_CHEAT_COMPARE_EN
        e.cmp_en  = code_w[CODE_FLAGS_LSB + 2];
        e.compare = code_w[CODE_CMP_LSB +: 32];
`endif
        e.replace = code_w[CODE_REPL_LSB +: 32];
        return e;
    endfunction

endpackage

// File: rtl/gba_cheat_engine_if.sv
// Gamepak read-path bundle between the SDRAM return data and the core.
interface gba_cheat_engine_if #(
    parameter int ADDR_W = 24
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       mem_dout1;
    logic [31:0]       mem_dout2;
    logic              mem_ack;
    logic [31:0]       rd_data1;
    logic [31:0]       rd_data2;
    logic              rd_done;

    modport master (
        output rd_req, rd_addr, mem_dout1, mem_dout2, mem_ack,
        input  rd_data1, rd_data2, rd_done
    );

    modport slave (
        input  rd_req, rd_addr, mem_dout1, mem_dout2, mem_ack,
        output rd_data1, rd_data2, rd_done
    );
endinterface

// File: rtl/gba_cheat_lane_patch.sv
// Combinational patch of one dword with a single cheat entry.
// Build option: GBA_CHEAT_COMPARE_EN gates replacement on the compare value.
module gba_cheat_lane_patch
    import gba_cheat_pkg::*;
(
    input  cheat_entry_t entry_i,
    input  logic [31:0]  data_i,
    output logic [31:0]  data_o
);

    logic [4:0]  byte_sh_s;
    logic [4:0]  half_sh_s;
    logic [7:0]  orig_b_s;
    logic [15:0] orig_h_s;
    logic        cmp_b_s;
    logic        cmp_h_s;
    logic        cmp_w_s;
    logic        unused_s;

    assign byte_sh_s = {entry_i.addr[1:0], 3'b000};
    assign half_sh_s = {entry_i.addr[1], 4'b0000};
    assign orig_b_s  = data_i[byte_sh_s +: 8];
    assign orig_h_s  = data_i[half_sh_s +: 16];
    assign unused_s  = ^{entry_i.valid, entry_i.addr[25:2]};

`ifdef GBA_CHEAT_COMPARE_EN
    assign cmp_b_s = !entry_i.cmp_en || (orig_b_s == entry_i.compare[7:0]);
    assign cmp_h_s = !entry_i.cmp_en || (orig_h_s == entry_i.compare[15:0]);
    assign cmp_w_s = !entry_i.cmp_en || (data_i == entry_i.compare);
`else
    assign cmp_b_s = 1'b1;
    assign cmp_h_s = 1'b1;
    assign cmp_w_s = 1'b1;
`endif

    // Replace the lane selected by size and the low address bits
    always_comb begin
        data_o = data_i;
        case (entry_i.size)
            SZ_BYTE: data_o[byte_sh_s +: 8]  = cmp_b_s ? entry_i.replace[7:0]  : orig_b_s;
            SZ_HALF: data_o[half_sh_s +: 16] = cmp_h_s ? entry_i.replace[15:0] : orig_h_s;
            SZ_WORD: data_o = cmp_w_s ? entry_i.replace : data_i;
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/gba_cheat_engine.sv
// Runtime cheat patcher on the gamepak read path: code table, load FSM, patch.
// Build option: GBA_CHEAT_COMPARE_EN enables conditional (compare) codes.
module gba_cheat_engine
    import gba_cheat_pkg::*;
#(
    parameter int MAX_CODES = 32,
    parameter int ADDR_W    = 24
) (
    input  logic                             clk_sys,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic                             clear,
    input  logic [128:0]                     code,
    gba_cheat_engine_if.slave                bus,
    output logic [$clog2(MAX_CODES+1)-1:0]   code_count,
    output logic                             table_full
);

    localparam int CNT_W = $clog2(MAX_CODES + 1);
    localparam int IDX_W = (MAX_CODES > 1) ? $clog2(MAX_CODES) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;

    logic [1:0]           state_q, state_d;
    cheat_entry_t         tbl_q [MAX_CODES];
    cheat_entry_t         cap_q;
    logic                 hit_q;
    logic                 slot_ok_q;
    logic [IDX_W-1:0]     slot_q;
    logic [CNT_W-1:0]     count_q;
    logic                 table_full_q;

    logic [MAX_CODES-1:0] hit_vec_s, free_vec_s, match1_s, match2_s;
    logic [MAX_CODES-1:0] match1_q, match2_q;
    logic [ADDR_W-1:0]    rd_addr_p1_s;
    cheat_entry_t         ent1_s, ent2_s;
    logic [31:0]          patch1_s, patch2_s;
    logic [31:0]          rd_data1_q, rd_data2_q;
    logic                 rd_done_q;
    logic                 unused_s;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [MAX_CODES-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_CODES - 1; i >= 0; i--) begin
            idx = vec[i] ? IDX_W'(i) : idx;
        end
        return idx;
    endfunction

`ifdef GBA_CHEAT_COMPARE_EN
    assign unused_s = ^{code[127:99], code[95:90]};
`else
    assign unused_s = ^{code[127:98], code[95:90], code[63:32]};
`endif

    assign rd_addr_p1_s = bus.rd_addr + ADDR_W'(1);

    // Table lookups: load-side hit/free search and read-side match vectors
    always_comb begin
        hit_vec_s  = '0;
        free_vec_s = '0;
        match1_s   = '0;
        match2_s   = '0;
        for (int i = 0; i < MAX_CODES; i++) begin
            hit_vec_s[i]  = tbl_q[i].valid && (tbl_q[i].addr == cap_q.addr);
            free_vec_s[i] = !tbl_q[i].valid;
            match1_s[i]   = tbl_q[i].valid && (tbl_q[i].size != SZ_NONE) &&
                            (tbl_q[i].addr[25:2] == 24'(bus.rd_addr));
            match2_s[i]   = tbl_q[i].valid && (tbl_q[i].size != SZ_NONE) &&
                            (tbl_q[i].addr[25:2] == 24'(rd_addr_p1_s));
        end
    end

    // Load FSM next state; strobes outside IDLE are ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = code[CODE_STROBE_BIT] ? ST_SEARCH : ST_IDLE;
            ST_SEARCH: state_d = ST_WRITE;
            ST_WRITE:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Load FSM state, code table and occupancy; clear overrides loading
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cap_q        <= '0;
            hit_q        <= 1'b0;
            slot_ok_q    <= 1'b0;
            slot_q       <= '0;
            count_q      <= '0;
            table_full_q <= 1'b0;
            for (int i = 0; i < MAX_CODES; i++) tbl_q[i] <= '0;
        end else if (clear) begin
            state_q      <= ST_IDLE;
            hit_q        <= 1'b0;
            slot_ok_q    <= 1'b0;
            count_q      <= '0;
            table_full_q <= 1'b0;
            for (int i = 0; i < MAX_CODES; i++) tbl_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (code[CODE_STROBE_BIT]) cap_q <= code_to_entry(code);
                    else                       cap_q <= cap_q;
                end
                ST_SEARCH: begin
                    hit_q     <= |hit_vec_s;
                    slot_ok_q <= (|hit_vec_s) || (|free_vec_s);
                    slot_q    <= (|hit_vec_s) ? lowest_idx(hit_vec_s) : lowest_idx(free_vec_s);
                end
                ST_WRITE: begin
                    if (slot_ok_q) begin
                        tbl_q[slot_q] <= cap_q;
                        if (!hit_q) count_q <= count_q + CNT_W'(1);
                        else        count_q <= count_q;
                    end else begin
                        table_full_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ent1_s = tbl_q[lowest_idx(match1_q)];
    assign ent2_s = tbl_q[lowest_idx(match2_q)];

    gba_cheat_lane_patch u_patch1 (
        .entry_i (ent1_s),
        .data_i  (bus.mem_dout1),
        .data_o  (patch1_s)
    );

    gba_cheat_lane_patch u_patch2 (
        .entry_i (ent2_s),
        .data_i  (bus.mem_dout2),
        .data_o  (patch2_s)
    );

    // Read path: latch matches on request, patch and register data on ack
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            match1_q   <= '0;
            match2_q   <= '0;
            rd_data1_q <= 32'h0000_0000;
            rd_data2_q <= 32'h0000_0000;
            rd_done_q  <= 1'b0;
        end else begin
            rd_done_q <= bus.mem_ack;
            if (clear) begin
                match1_q <= '0;
                match2_q <= '0;
            end else if (bus.rd_req) begin
                match1_q <= match1_s;
                match2_q <= match2_s;
            end else begin
                match1_q <= match1_q;
                match2_q <= match2_q;
            end
            if (bus.mem_ack) begin
                rd_data1_q <= (enable && (|match1_q)) ? patch1_s : bus.mem_dout1;
                rd_data2_q <= (enable && (|match2_q)) ? patch2_s : bus.mem_dout2;
            end else begin
                rd_data1_q <= rd_data1_q;
                rd_data2_q <= rd_data2_q;
            end
        end
    end

    assign bus.rd_data1 = rd_data1_q;
    assign bus.rd_data2 = rd_data2_q;
    assign bus.rd_done  = rd_done_q;
    assign code_count   = count_q;
    assign table_full   = table_full_q;

endmodule

// File: tb/tb_gba_cheat_engine.sv
// Directed, table-driven bench for gba_cheat_engine (works with or without GBA_CHEAT_COMPARE_EN).
module tb_gba_cheat_engine;

    localparam int MAXC = 4;
    localparam int AW   = 24;

`ifdef GBA_CHEAT_COMPARE_EN
    localparam logic [31:0] EXP_HALF_NE = 32'h0000_5556;
`else
    localparam logic [31:0] EXP_HALF_NE = 32'h0000_BEEF;
`endif

    typedef struct {
        string       name;
        logic [23:0] addr;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        en;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         en    = 1'b1;
    logic         clr   = 1'b0;
    logic [128:0] code  = '0;
    logic [2:0]   cnt;
    logic         full;
    int           n_tests = 0;
    int           n_fail  = 0;
    vec_t         vecs [8];
    logic [31:0]  r1, r2;
    logic         done;

    gba_cheat_engine_if #(.ADDR_W(AW)) bus ();

    gba_cheat_engine #(.MAX_CODES(MAXC), .ADDR_W(AW)) dut (
        .clk_sys    (clk),
        .reset_n    (rst_n),
        .enable     (en),
        .clear      (clr),
        .code       (code),
        .bus        (bus),
        .code_count (cnt),
        .table_full (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [31:0] flags, input logic [31:0] addr,
                        input logic [31:0] cmp, input logic [31:0] repl);
        @(posedge clk); #1;
        code = {1'b1, flags, addr, cmp, repl};
        @(posedge clk); #1;
        code = '0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [23:0] addr, input logic [31:0] d1, input logic [31:0] d2,
                           output logic [31:0] o1, output logic [31:0] o2, output logic o_done);
        @(posedge clk); #1;
        bus.rd_req  = 1'b1;
        bus.rd_addr = addr;
        @(posedge clk); #1;
        bus.rd_req  = 1'b0;
        @(posedge clk); #1;
        bus.mem_ack   = 1'b1;
        bus.mem_dout1 = d1;
        bus.mem_dout2 = d2;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        o_done = bus.rd_done;
        o1     = bus.rd_data1;
        o2     = bus.rd_data2;
    endtask

    initial begin
        vecs[0] = '{"word",     24'h000041, 32'h11223344, 32'hCAFEF00D, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[1] = '{"byte_d2",  24'h00003F, 32'h99887766, 32'h11223344, 1'b1, 32'h99887766, 32'h11AB3344};
        vecs[2] = '{"byte_d1",  24'h000040, 32'h11223344, 32'h55667788, 1'b1, 32'h11AB3344, 32'hDEADBEEF};
        vecs[3] = '{"half_eq",  24'h000080, 32'h00005555, 32'h00000000, 1'b1, 32'h0000BEEF, 32'h00000000};
        vecs[4] = '{"half_ne",  24'h000080, 32'h00005556, 32'h00000000, 1'b1, EXP_HALF_NE,  32'h00000000};
        vecs[5] = '{"half_d2",  24'h00007F, 32'h00000001, 32'hFFFF5555, 1'b1, 32'h00000001, 32'hFFFFBEEF};
        vecs[6] = '{"wrap",     24'hFFFFFF, 32'h01020304, 32'h01020304, 1'b1, 32'h01020304, 32'h5A020304};
        vecs[7] = '{"disabled", 24'h000041, 32'h11223344, 32'h55667788, 1'b0, 32'h11223344, 32'h55667788};

        bus.rd_req    = 1'b0;
        bus.rd_addr   = '0;
        bus.mem_dout1 = 32'h0;
        bus.mem_dout2 = 32'h0;
        bus.mem_ack   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_data1", bus.rd_data1, 32'h0);
        check("rst_data2", bus.rd_data2, 32'h0);
        check("rst_done",  {31'h0, bus.rd_done}, 32'h0);
        check("rst_count", {29'h0, cnt}, 32'h0);
        check("rst_full",  {31'h0, full}, 32'h0);
        rst_n = 1'b1;

        load(32'h2, 32'h0000_0104, 32'h0,      32'hDEADBEEF);
        load(32'h0, 32'h0000_0102, 32'h0,      32'h0000_00AB);
        load(32'h5, 32'h0000_0200, 32'h5555,   32'h0000_BEEF);
        load(32'h0, 32'h0000_0003, 32'h0,      32'h0000_005A);
        check("count_4", {29'h0, cnt}, 32'd4);
        check("full_0",  {31'h0, full}, 32'h0);

        for (int i = 0; i < 8; i++) begin
            en = vecs[i].en;
            do_read(vecs[i].addr, vecs[i].d1, vecs[i].d2, r1, r2, done);
            check({vecs[i].name, "_d1"}, r1, vecs[i].e1);
            check({vecs[i].name, "_d2"}, r2, vecs[i].e2);
            check({vecs[i].name, "_done"}, {31'h0, done}, 32'h1);
            @(posedge clk); #1;
            check({vecs[i].name, "_done_fall"}, {31'h0, bus.rd_done}, 32'h0);
            check({vecs[i].name, "_hold"}, bus.rd_data1, vecs[i].e1);
            en = 1'b1;
        end

        // Last request before the ack wins
        @(posedge clk); #1; bus.rd_req = 1'b1; bus.rd_addr = 24'h000041;
        @(posedge clk); #1; bus.rd_addr = 24'h00003F;
        @(posedge clk); #1; bus.rd_req = 1'b0;
        @(posedge clk); #1; bus.mem_ack = 1'b1; bus.mem_dout1 = 32'h99887766; bus.mem_dout2 = 32'h11223344;
        @(posedge clk); #1; bus.mem_ack = 1'b0;
        check("lastreq_d1", bus.rd_data1, 32'h99887766);
        check("lastreq_d2", bus.rd_data2, 32'h11AB3344);

        // Overflow drops the code and sets the sticky flag
        load(32'h2, 32'h0000_0300, 32'h0, 32'h12121212);
        check("ovf_count", {29'h0, cnt}, 32'd4);
        check("ovf_full",  {31'h0, full}, 32'h1);
        do_read(24'h0000C0, 32'h12345678, 32'h0, r1, r2, done);
        check("ovf_dropped", r1, 32'h12345678);

        // Reload an existing address; a strobe during SEARCH is ignored
        @(posedge clk); #1; code = {1'b1, 32'h2, 32'h0000_0104, 32'h0, 32'h0BADF00D};
        @(posedge clk); #1; code = {1'b1, 32'h2, 32'h0000_0104, 32'h0, 32'h77777777};
        @(posedge clk); #1; code = '0;
        repeat (3) @(posedge clk);
        #1;
        check("upd_count", {29'h0, cnt}, 32'd4);
        check("upd_full",  {31'h0, full}, 32'h1);
        do_read(24'h000041, 32'h11223344, 32'h55667788, r1, r2, done);
        check("upd_d1", r1, 32'h0BADF00D);
        check("upd_d2", r2, 32'h55667788);

        // Clear empties the table
        @(posedge clk); #1; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        check("clr_count", {29'h0, cnt}, 32'h0);
        check("clr_full",  {31'h0, full}, 32'h0);
        do_read(24'h000040, 32'h11223344, 32'h55667788, r1, r2, done);
        check("clr_d1", r1, 32'h11223344);
        check("clr_d2", r2, 32'h55667788);

        // Request during the WRITE cycle sees the pre-load table
        @(posedge clk); #1; code = {1'b1, 32'h2, 32'h0000_0104, 32'h0, 32'hCAFEBABE};
        @(posedge clk); #1; code = '0;
        @(posedge clk); #1; bus.rd_req = 1'b1; bus.rd_addr = 24'h000041;
        @(posedge clk); #1; bus.rd_req = 1'b0;
        @(posedge clk); #1; bus.mem_ack = 1'b1; bus.mem_dout1 = 32'h11223344; bus.mem_dout2 = 32'h0;
        @(posedge clk); #1; bus.mem_ack = 1'b0;
        check("preload_d1", bus.rd_data1, 32'h11223344);
        do_read(24'h000041, 32'h11223344, 32'h0, r1, r2, done);
        check("postload_d1", r1, 32'hCAFEBABE);
        check("postload_count", {29'h0, cnt}, 32'd1);

        // Reset between request and ack drops the ack
        @(posedge clk); #1; bus.rd_req = 1'b1; bus.rd_addr = 24'h000041;
        @(posedge clk); #1; bus.rd_req = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1; bus.mem_ack = 1'b1; bus.mem_dout1 = 32'h11223344; bus.mem_dout2 = 32'h55667788;
        @(posedge clk); #1; bus.mem_ack = 1'b0; rst_n = 1'b1;
        check("rstmid_done",  {31'h0, bus.rd_done}, 32'h0);
        check("rstmid_d1",    bus.rd_data1, 32'h0);
        check("rstmid_d2",    bus.rd_data2, 32'h0);
        check("rstmid_count", {29'h0, cnt}, 32'h0);
        @(posedge clk); #1;
        check("rstmid_done2", {31'h0, bus.rd_done}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
